// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_ctrl
// Purpose  : Frame sequencer for a parallel N-point FFT core. It collects a
//            serial valid/ready sample stream into one N-sample frame, holds
//            that frame on the core input while the core's fixed latency
//            elapses, captures the N results and replays them as a serial
//            valid/ready stream with a last flag on bin N-1.
// Ports    : clk           - clock, rising edge
//            arst_n        - asynchronous active-low reset
//            s_valid/s_ready/s_data    - input sample stream
//            fft_data_in   - frame to core, element i at [i*SW +: SW]
//            fft_data_out  - core result, same packing
//            m_valid/m_ready/m_data/m_last - output bin stream, bin 0 first
//            busy          - high while waiting on the core or draining
//            frame_cnt     - completed-frame counter (optional, see below)
// Options  : FFT_FRAME_CTRL_FRAME_CNT_EN - when defined, adds the 16-bit
//            frame_cnt output, incremented on every last-bin transfer.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_ctrl #(
    parameter int N            = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int FFT_LATENCY  = 1
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      s_valid,
    input  logic [SAMPLE_WIDTH-1:0]   s_data,
    output logic                      s_ready,
    output logic [N*SAMPLE_WIDTH-1:0] fft_data_in,
    input  logic [N*SAMPLE_WIDTH-1:0] fft_data_out,
    output logic                      m_valid,
    output logic [SAMPLE_WIDTH-1:0]   m_data,
    output logic                      m_last,
    input  logic                      m_ready,
    output logic                      busy
`ifdef FFT_FRAME_CTRL_FRAME_CNT_EN
    ,
    output logic [15:0]               frame_cnt
`endif
);

    localparam int c_idx_w = (N > 1) ? $clog2(N) : 1;
    localparam int c_lat_w = (FFT_LATENCY > 0) ? $clog2(FFT_LATENCY + 1) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N - 1);
    localparam logic [c_lat_w-1:0] c_lat_init = c_lat_w'(FFT_LATENCY);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t                      r_state;
    logic [c_idx_w-1:0]          r_wr_idx;
    logic [c_idx_w-1:0]          r_rd_idx;
    logic [c_lat_w-1:0]          r_lat_cnt;
    logic [N*SAMPLE_WIDTH-1:0]   r_in_buf;
    logic [N*SAMPLE_WIDTH-1:0]   r_out_buf;

    logic w_s_fire;
    logic w_m_fire;

    // Handshakes come straight from the state register so neither ready nor
    // valid depends combinationally on the partner's signal.
    assign s_ready     = (r_state == ST_COLLECT);
    assign m_valid     = (r_state == ST_DRAIN);
    assign busy        = (r_state == ST_WAIT) || (r_state == ST_DRAIN);
    assign w_s_fire    = s_valid && s_ready;
    assign w_m_fire    = m_valid && m_ready;

    // in_buf is only written in COLLECT, so the core input is frozen for the
    // whole WAIT period without any extra holding register.
    assign fft_data_in = r_in_buf;
    assign m_data      = r_out_buf[r_rd_idx*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign m_last      = m_valid && (r_rd_idx == c_last_idx);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= ST_COLLECT;
            r_wr_idx  <= '0;
            r_rd_idx  <= '0;
            r_lat_cnt <= '0;
            r_in_buf  <= '0;
            r_out_buf <= '0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (w_s_fire) begin
                        r_in_buf[r_wr_idx*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= s_data;
                        if (r_wr_idx == c_last_idx) begin
                            r_wr_idx  <= '0;
                            r_lat_cnt <= c_lat_init;
                            r_state   <= ST_WAIT;
                        end else begin
                            r_wr_idx  <= r_wr_idx + c_idx_w'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    // Count down the core latency, then sample the result on
                    // the edge where the counter is already zero.
                    if (r_lat_cnt != '0) begin
                        r_lat_cnt <= r_lat_cnt - c_lat_w'(1);
                    end else begin
                        r_out_buf <= fft_data_out;
                        r_state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_m_fire) begin
                        if (r_rd_idx == c_last_idx) begin
                            r_rd_idx <= '0;
                            r_state  <= ST_COLLECT;
                        end else begin
                            r_rd_idx <= r_rd_idx + c_idx_w'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_COLLECT;
                end
            endcase
        end
    end

`ifdef FFT_FRAME_CTRL_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Free-running modulo-2^16 count of completed output frames.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_frame_cnt <= 16'h0000;
        end else if (w_m_fire && m_last) begin
            r_frame_cnt <= r_frame_cnt + 16'h0001;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire
